// File: rtl/adder_pkg.sv
// Shared widths and elaboration-time helpers for the pipelined adder/subtractor.
package adder_pkg;

    localparam int FP_MANT_A_W = 47;
    localparam int FP_MANT_B_W = 46;
    localparam int FP_SEG_W    = 16;

    function automatic int ceil_div(int n, int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int num_stages(int w, int seg);
        return ceil_div(w, seg);
    endfunction

    // The top segment only covers whatever the full-width segments leave over.
    function automatic int last_seg_w(int w, int seg);
        return w - (num_stages(w, seg) - 1) * seg;
    endfunction

endpackage

// File: rtl/pipelined_unsigned_adder_if.sv
// Operand/result handshake bundle for pipelined_unsigned_adder.
// The carry-in wire exists only when PIPE_ADD_CARRY_IN_EN is defined.
interface pipelined_unsigned_adder_if #(
    parameter int WIDTH_A = 47,
    parameter int WIDTH_B = 46
);
    localparam int W = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;

    // A transfer happens on a rising clock edge where valid and ready are both high;
    // a source holding valid keeps its payload stable until that edge.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_A-1:0] in_a;
    logic [WIDTH_B-1:0] in_b;
    logic               in_sub;
`ifdef PIPE_ADD_CARRY_IN_EN
    logic               in_cin;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [W:0]         out_sum;

`ifdef PIPE_ADD_CARRY_IN_EN
    modport master (output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
                    input  in_ready, out_valid, out_sum);
    modport slave  (input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
                    output in_ready, out_valid, out_sum);
`else
    modport master (output in_valid, in_a, in_b, in_sub, out_ready,
                    input  in_ready, out_valid, out_sum);
    modport slave  (input  in_valid, in_a, in_b, in_sub, out_ready,
                    output in_ready, out_valid, out_sum);
`endif

endinterface

// File: rtl/adder_pipe_segment.sv
// One carry segment: adds bits [LO +: SW] of the skewed operands plus the
// registered carry, and forwards result, operands and carry-out through a valid/ready stage.
module adder_pipe_segment #(
    parameter int W  = 47,
    parameter int LO = 0,
    parameter int SW = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [W-1:0] res_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         carry_in,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [W-1:0] res_out,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         carry_out
);
    localparam logic [W-1:0] SEG_MASK = ({W{1'b1}} >> (W - SW)) << LO;

    logic [SW:0]  seg_sum;
    logic [W-1:0] res_next;

    assign seg_sum  = {1'b0, a_in[LO +: SW]} + {1'b0, b_in[LO +: SW]} + (SW+1)'(carry_in);
    assign res_next = (res_in & ~SEG_MASK) | (W'(seg_sum[SW-1:0]) << LO);

    // An empty stage, or one whose content moves on this edge, can take new data.
    assign ready_in = !valid_out | ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            res_out   <= '0;
            a_out     <= '0;
            b_out     <= '0;
            carry_out <= 1'b0;
        end else if (ready_in) begin
            valid_out <= valid_in;
            if (valid_in) begin
                res_out   <= res_next;
                a_out     <= a_in;
                b_out     <= b_in;
                carry_out <= seg_sum[SW];
            end
        end
    end

endmodule

// File: rtl/pipelined_unsigned_adder.sv
// Pipelined unsigned adder/subtractor: one register stage per SEG_W-bit carry segment.
// Define PIPE_ADD_CARRY_IN_EN to add the in_cin carry/borrow input.
module pipelined_unsigned_adder
    import adder_pkg::*;
#(
    parameter int WIDTH_A = FP_MANT_A_W,
    parameter int WIDTH_B = FP_MANT_B_W,
    parameter int SEG_W   = FP_SEG_W
) (
    input logic                        clk,
    input logic                        rst_n,
    pipelined_unsigned_adder_if.slave  bus
);
    localparam int W      = max_int(WIDTH_A, WIDTH_B);
    localparam int STAGES = num_stages(W, SEG_W);
    localparam int LAST_W = last_seg_w(W, SEG_W);

    logic [W-1:0] a_ext;
    logic [W-1:0] b_zext;
    logic [W-1:0] b_ext;
    logic         carry0;

    assign a_ext  = W'(bus.in_a);
    assign b_zext = W'(bus.in_b);
    // Subtraction is A + ~B + 1, so the +1 rides in on the segment-0 carry.
    assign b_ext  = bus.in_sub ? ~b_zext : b_zext;
`ifdef PIPE_ADD_CARRY_IN_EN
    assign carry0 = bus.in_sub ^ bus.in_cin;
`else
    assign carry0 = bus.in_sub;
`endif

    logic         valid_p [0:STAGES];
    logic         ready_p [0:STAGES];
    logic [W-1:0] res_p   [0:STAGES];
    logic [W-1:0] a_p     [0:STAGES];
    logic [W-1:0] b_p     [0:STAGES];
    logic         carry_p [0:STAGES];

    assign valid_p[0]      = bus.in_valid;
    assign res_p[0]        = '0;
    assign a_p[0]          = a_ext;
    assign b_p[0]          = b_ext;
    assign carry_p[0]      = carry0;
    assign ready_p[STAGES] = bus.out_ready;
    assign bus.in_ready    = ready_p[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        adder_pipe_segment #(
            .W  (W),
            .LO (k * SEG_W),
            .SW ((k == STAGES - 1) ? LAST_W : SEG_W)
        ) u_seg (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_in  (valid_p[k]),
            .ready_in  (ready_p[k]),
            .res_in    (res_p[k]),
            .a_in      (a_p[k]),
            .b_in      (b_p[k]),
            .carry_in  (carry_p[k]),
            .valid_out (valid_p[k+1]),
            .ready_out (ready_p[k+1]),
            .res_out   (res_p[k+1]),
            .a_out     (a_p[k+1]),
            .b_out     (b_p[k+1]),
            .carry_out (carry_p[k+1])
        );
    end

    assign bus.out_valid = valid_p[STAGES];
    assign bus.out_sum   = {carry_p[STAGES], res_p[STAGES]};

    // Every operand bit is consumed by the last stage; its forwarded copies go nowhere.
    logic unused_ops;
    assign unused_ops = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_pipelined_unsigned_adder.sv
// Bench for pipelined_unsigned_adder: directed cases, stall/reset behaviour and
// randomized traffic scored against an arithmetic reference model.
module tb_pipelined_unsigned_adder;
    localparam int WA     = 47;
    localparam int WB     = 46;
    localparam int SEG    = 16;
    localparam int W      = 47;
    localparam int STAGES = 3;
`ifdef PIPE_ADD_CARRY_IN_EN
    localparam int N_RAND = 10000;
`else
    localparam int N_RAND = 1500;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_unsigned_adder_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

    pipelined_unsigned_adder #(.WIDTH_A(WA), .WIDTH_B(WB), .SEG_W(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0;
    int n_out = 0;
    bit saw_full = 0;
    bit done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic logic [W:0] ref_model(logic [63:0] a, logic [63:0] b, logic sub, logic cin);
        logic [63:0] r;
        if (!sub) begin
            r = a + b + 64'(cin);
        end else begin
            r = a - b - 64'(cin);
            r[W] = (a >= b + 64'(cin));
        end
        return r[W:0];
    endfunction

    function automatic logic [63:0] rand_op(int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'($urandom_range(0, 20));
            3:       return (64'hFFFF << (SEG * $urandom_range(0, 1))) & mask;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    // Called near a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input logic cin, input logic [W:0] exp);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = WA'(a);
        bus.in_b     = WB'(b);
        bus.in_sub   = sub;
`ifdef PIPE_ADD_CARRY_IN_EN
        bus.in_cin   = cin;
`else
        if (cin) $display("note: carry-in ignored in this build");
`endif
        #1;
        while (!bus.in_ready) begin
            saw_full = 1;
            check("full_depth", 64'(exp_q.size()), 64'(STAGES));
            waited++;
            if (waited > 200) begin
                check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        exp_q.push_back(exp);
        n_vec++;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        bit         stall_prev;
        logic [W:0] held;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_hold", 64'(bus.out_sum), 64'(held));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h, expected no output", bus.out_sum);
                    end else begin
                        check("result", 64'(bus.out_sum), 64'(exp_q.pop_front()));
                        n_out++;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held = bus.out_sum;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lat;
        int seen;
        int waited;
        logic [63:0] a, b;
        logic sub, cin;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
`ifdef PIPE_ADD_CARRY_IN_EN
        bus.in_cin    = 1'b0;
`endif
        bus.out_ready = 1'b1;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_sum", 64'(bus.out_sum), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Max-width add and its latency from the accepting edge.
        send(64'h7FFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF, 1'b0, 1'b0, 48'hBFFF_FFFF_FFFE);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            #1;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'(STAGES));
        idle(4);

        send(64'h0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 48'h0001_0000_0000);
        send(64'd7, 64'd5, 1'b1, 1'b0, 48'h8000_0000_0002);
        send(64'd5, 64'd7, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFE);
        send(64'h1234, 64'h1234, 1'b1, 1'b0, 48'h8000_0000_0000);
        send(64'd0, 64'h3FFF_FFFF_FFFF, 1'b1, 1'b0, 48'h4000_0000_0001);
`ifdef PIPE_ADD_CARRY_IN_EN
        send(64'd0, 64'd0, 1'b0, 1'b1, 48'h0000_0000_0001);
        send(64'd7, 64'd5, 1'b1, 1'b1, 48'h8000_0000_0001);
`endif
        idle(6);
        check("drained_directed", 64'(exp_q.size()), 64'd0);

        // Back-to-back stream with a 4-cycle output stall in the middle.
        saw_full = 0;
        fork
            for (int i = 0; i < 8; i++) begin
                a = rand_op(WA);
                b = rand_op(WB);
                sub = i[0];
                send(a, b, sub, 1'b0, ref_model(a, b, sub, 1'b0));
            end
            begin
                repeat (3) @(posedge clk);
                #2 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2 bus.out_ready = 1'b1;
            end
        join
        check("in_ready_fell", 64'(saw_full), 64'd1);
        idle(6);
        check("drained_stream", 64'(exp_q.size()), 64'd0);

        // Reset with a full, stalled pipeline.
        @(posedge clk);
        #2 bus.out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(64'(i + 1), 64'd1, 1'b0, 1'b0, ref_model(64'(i + 1), 64'd1, 1'b0, 1'b0));
        #1;
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_reset_out_sum", 64'(bus.out_sum), 64'd0);
        check("mid_reset_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("no_output_after_reset", 64'(seen), 64'd0);
        n_out = 0;
        n_vec = 0;

        // Randomized traffic with random gaps and back-pressure.
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    a = rand_op(WA);
                    b = rand_op(WB);
                    sub = 1'($urandom_range(0, 1));
`ifdef PIPE_ADD_CARRY_IN_EN
                    cin = 1'($urandom_range(0, 1));
`else
                    cin = 1'b0;
`endif
                    send(a, b, sub, cin, ref_model(a, b, sub, cin));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #2 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        idle(2);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("outputs_match_inputs", 64'(n_out), 64'(n_vec));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
